// File: rtl/lzs_decode_pkg.sv
// Shared constants and helpers for the LZS decode path.
// Covers the bit aligner and the token width codes used by the controller.
package lzs_decode_pkg;

    localparam int STREAM_W = 13;
    localparam int IN_W     = 32;
    localparam int BUF_W    = 64;
    localparam int CNT_W    = 7;

    localparam logic [8:0] LZS_END_MARKER = 9'b110000000;

    localparam logic [3:0] LZS_W_LIT   = 4'd9;
    localparam logic [3:0] LZS_W_OFF7  = 4'd9;
    localparam logic [3:0] LZS_W_OFF11 = 4'd13;
    localparam logic [3:0] LZS_W_LEN2  = 4'd2;
    localparam logic [3:0] LZS_W_LEN4  = 4'd4;

    // Number of bits a popped word contributes; a final word may be partial.
    function automatic logic [6:0] refill_bits(input logic last, input logic [1:0] nbytes);
        logic [6:0] n;
        if (last) begin
            case (nbytes)
                2'd1:    n = 7'd8;
                2'd2:    n = 7'd16;
                2'd3:    n = 7'd24;
                default: n = 7'd32;
            endcase
        end else begin
            n = 7'd32;
        end
        return n;
    endfunction

    // Keep only the top n bits of a word so the buffer stays zero below its valid region.
    function automatic logic [31:0] top_mask(input logic [6:0] n);
        return ~(32'hFFFF_FFFF >> n);
    endfunction

endpackage

// File: rtl/decode_bits_shift.sv
// Left barrel shift of the bit buffer followed by the refill OR-merge.
// A masked word is placed directly below the surviving valid bits.
module decode_bits_shift
    import lzs_decode_pkg::*;
(
    input  logic [63:0] bits_in,
    input  logic [3:0]  shamt,
    input  logic        clear,
    input  logic [31:0] word,
    input  logic [6:0]  place,
    input  logic        merge,
    output logic [63:0] bits_out
);

    logic [63:0] shifted_s;
    logic [63:0] placed_s;

    // Consume shift, then drop the new word in at offset 'place' from the top.
    always_comb begin
        shifted_s = 64'd0;
        placed_s  = 64'd0;
        bits_out  = 64'd0;
        if (clear) begin
            shifted_s = 64'd0;
        end else begin
            shifted_s = bits_in << shamt;
        end
        placed_s = {word, 32'd0} >> place;
        if (merge) begin
            bits_out = shifted_s | placed_s;
        end else begin
            bits_out = shifted_s;
        end
    end

endmodule

// File: rtl/decode_bits.sv
// Bit-stream aligner feeding the LZS decode controller.
// Holds a 64-bit left-justified buffer and exposes its top 13 bits.
module decode_bits
    import lzs_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        in_ack,
    output logic [12:0] stream_data,
    output logic        stream_valid,
    input  logic [3:0]  stream_width,
    input  logic        stream_ack,
    output logic [6:0]  bit_cnt,
    output logic        done,
    output logic        err
);

    logic [63:0] bits_q, bits_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic        last_seen_q, last_seen_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        ack_ok_s;
    logic [3:0]  shamt_s;
    logic        clear_s;
    logic [6:0]  base_cnt_s;
    logic [6:0]  refill_n_s;
    logic [31:0] word_s;

    assign in_ack       = in_valid & ~rst & ~last_seen_q & (bit_cnt_q <= 7'd32);
    assign stream_data  = bits_q[63:51];
    assign stream_valid = (bit_cnt_q >= 7'd13) | (last_seen_q & (bit_cnt_q != 7'd0));
    assign bit_cnt      = bit_cnt_q;
    assign done         = done_q;
    assign err          = err_q;

    assign refill_n_s = refill_bits(in_last, in_bytes);
    assign word_s     = in_data & top_mask(refill_n_s);

    decode_bits_shift u_shift (
        .bits_in  (bits_q),
        .shamt    (shamt_s),
        .clear    (clear_s),
        .word     (word_s),
        .place    (base_cnt_s),
        .merge    (in_ack),
        .bits_out (bits_d)
    );

    // Consume/error decision and next counts; an over-wide ack never shifts.
    always_comb begin
        ack_ok_s    = stream_ack & stream_valid;
        shamt_s     = 4'd0;
        clear_s     = 1'b0;
        base_cnt_s  = bit_cnt_q;
        err_d       = err_q;
        bit_cnt_d   = bit_cnt_q;
        last_seen_d = last_seen_q;
        if (ack_ok_s) begin
            if (stream_width > 4'd13) begin
                err_d = 1'b1;
            end else if ({3'd0, stream_width} > bit_cnt_q) begin
                err_d      = 1'b1;
                clear_s    = 1'b1;
                base_cnt_s = 7'd0;
            end else begin
                shamt_s    = stream_width;
                base_cnt_s = bit_cnt_q - {3'd0, stream_width};
            end
        end else begin
            shamt_s = 4'd0;
        end
        if (in_ack) begin
            bit_cnt_d   = base_cnt_s + refill_n_s;
            last_seen_d = last_seen_q | in_last;
        end else begin
            bit_cnt_d   = base_cnt_s;
            last_seen_d = last_seen_q;
        end
        done_d = last_seen_d & (bit_cnt_d == 7'd0);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q      <= 64'd0;
            bit_cnt_q   <= 7'd0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            bits_q      <= bits_d;
            bit_cnt_q   <= bit_cnt_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_decode_bits.sv
// Self-checking bench for decode_bits: a bit-queue reference model feeds a
// scoreboard of expected post-edge state, compared one cycle later.
module tb_decode_bits;
    import lzs_decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_bytes;
    logic        in_ack;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic [3:0]  stream_width;
    logic        stream_ack;
    logic [6:0]  bit_cnt;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [6:0]  cnt;
        logic        sv;
        logic [12:0] sd;
        logic        dn;
        logic        er;
    } exp_t;
    exp_t sb_q[$];

    bit mq[$];
    bit m_last = 1'b0;
    bit m_err  = 1'b0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    decode_bits dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .in_ack       (in_ack),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_width (stream_width),
        .stream_ack   (stream_ack),
        .bit_cnt      (bit_cnt),
        .done         (done),
        .err          (err)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic m_sv();
        return (mq.size() >= 13) || (m_last && mq.size() != 0);
    endfunction

    function automatic logic [12:0] m_sd();
        logic [12:0] r;
        r = 13'd0;
        for (int i = 0; i < 13; i++) begin
            if (i < mq.size()) r[12-i] = mq[i];
        end
        return r;
    endfunction

    function automatic logic m_in_ack();
        return in_valid && !rst && !m_last && (mq.size() <= 32);
    endfunction

    task automatic model_step();
        bit acc;
        bit ackv;
        int n;
        if (rst) begin
            mq.delete();
            m_last = 1'b0;
            m_err  = 1'b0;
            m_done = 1'b0;
        end else begin
            acc  = m_in_ack();
            ackv = stream_ack && m_sv();
            if (ackv) begin
                if (stream_width > 13) begin
                    m_err = 1'b1;
                end else if (int'(stream_width) > mq.size()) begin
                    m_err = 1'b1;
                    mq.delete();
                end else begin
                    repeat (int'(stream_width)) void'(mq.pop_front());
                end
            end
            if (acc) begin
                n = !in_last ? 32 : (in_bytes == 2'd0 ? 32 : 8 * int'(in_bytes));
                for (int i = 0; i < n; i++) mq.push_back(in_data[31-i]);
                if (in_last) m_last = 1'b1;
            end
            m_done = m_last && (mq.size() == 0);
        end
    endtask

    // One clock: drive at negedge, check in_ack, push expectation, compare after posedge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] d, input logic l,
                         input logic [1:0] b, input logic a, input logic [3:0] w);
        exp_t e;
        in_valid = v; in_data = d; in_last = l; in_bytes = b;
        stream_ack = a; stream_width = w;
        #1;
        check_eq({tag, "_in_ack"}, {63'd0, in_ack}, {63'd0, m_in_ack()});
        model_step();
        e.tag = tag; e.cnt = 7'(mq.size()); e.sv = m_sv(); e.sd = m_sd();
        e.dn = m_done; e.er = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq({e.tag, "_cnt"}, {57'd0, bit_cnt}, {57'd0, e.cnt});
        check_eq({e.tag, "_sv"}, {63'd0, stream_valid}, {63'd0, e.sv});
        check_eq({e.tag, "_sd"}, {51'd0, stream_data}, {51'd0, e.sd});
        check_eq({e.tag, "_done"}, {63'd0, done}, {63'd0, e.dn});
        check_eq({e.tag, "_err"}, {63'd0, err}, {63'd0, e.er});
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_A5A5; in_last = 1'b0;
        in_bytes = 2'd0; stream_ack = 1'b0; stream_width = 4'd0;
        @(negedge clk);

        cycle("rst0", 1'b1, 32'hA5A5_A5A5, 1'b0, 2'd0, 1'b0, 4'd0);
        cycle("rst1", 1'b1, 32'hA5A5_A5A5, 1'b0, 2'd0, 1'b0, 4'd0);
        check_eq("p1_data", {51'd0, stream_data}, 64'h0);
        rst = 1'b0;
        cycle("push_a5", 1'b1, 32'hA5A5_A5A5, 1'b0, 2'd0, 1'b0, 4'd0);
        check_eq("p2_sd", {51'd0, stream_data}, 64'h14B4);
        check_eq("p2_cnt", {57'd0, bit_cnt}, 64'd32);
        cycle("ack9", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 4'd9);
        check_eq("p3_sd", {51'd0, stream_data}, 64'h0969);
        cycle("ack13_push", 1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0, 1'b1, 4'd13);
        check_eq("p4_cnt", {57'd0, bit_cnt}, 64'd42);
        cycle("full_hold", 1'b1, 32'h1234_5678, 1'b0, 2'd0, 1'b0, 4'd0);
        cycle("w0_noop", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 4'd0);
        cycle("w14_err", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 4'd14);
        cycle("ack13b", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 4'd13);

        rst = 1'b1;
        cycle("midrst", 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0, 1'b1, 4'd3);
        rst = 1'b0;
        cycle("last_b1", 1'b1, 32'hC012_3456, 1'b1, 2'd1, 1'b0, 4'd0);
        check_eq("p5_sd", {51'd0, stream_data}, 64'h1800);
        cycle("after_last", 1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0, 1'b0, 4'd0);
        cycle("ack8", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 4'd8);
        check_eq("p5_done", {63'd0, done}, 64'd1);

        rst = 1'b1;
        cycle("rst2", 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 4'd0);
        rst = 1'b0;
        cycle("last_b1b", 1'b1, 32'hC012_3456, 1'b1, 2'd1, 1'b0, 4'd0);
        cycle("ack9_over", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 4'd9);
        check_eq("p6_err", {63'd0, err}, 64'd1);
        cycle("err_sticky", 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 4'd0);

        rst = 1'b1;
        cycle("rst3", 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 4'd0);
        rst = 1'b0;
        cycle("ack_invalid", 1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 4'd5);
        cycle("fill1", 1'b1, 32'h8000_0001, 1'b0, 2'd0, 1'b0, 4'd0);
        cycle("fill2", 1'b1, 32'h7FFF_FFFE, 1'b0, 2'd0, 1'b0, 4'd0);
        check_eq("fill_cnt", {57'd0, bit_cnt}, 64'd64);
        cycle("fill_block", 1'b1, 32'h5555_5555, 1'b0, 2'd0, 1'b1, 4'd13);
        cycle("last_b0", 1'b1, 32'h0F0F_0F0F, 1'b1, 2'd0, 1'b1, 4'd13);

        for (int k = 0; k < 300; k++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 19) == 0) ? 4'd14 : 4'($urandom_range(0, 13));
            rst = (k % 50 == 49);
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 15) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
